// File: rtl/bram_fifo_ctrl.sv
// Valid/ready FIFO controller around a 1R1W block RAM with a registered,
// first-word-fall-through pop stage. The BRAM read register is the output stage.

// Simple dual-port RAM: one write port, one registered read port, optional
// write-to-read bypass when both ports address the same entry in one cycle.
module bram_1r1w #(
   parameter int unsigned ADDR_WIDTH  = 4,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter bit          READ_BYPASS = 1'b1
) (
   input  logic                  clk,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_rd_en,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);
   localparam int unsigned DEPTH = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic                  w_bypass;

   assign w_bypass = READ_BYPASS && i_wr_en && (i_wr_addr == i_rd_addr);

   // Storage write and registered read with same-address bypass
   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      if (i_rd_en) r_rd_data <= w_bypass ? i_wr_data : r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;
endmodule

module bram_fifo_ctrl #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  push_valid,
   output logic                  push_ready,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic                  pop_valid,
   input  logic                  pop_ready,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty
);
   localparam int unsigned CW = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0] C_DEPTH = CW'(2**ADDR_WIDTH);

   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_pop_valid;
   logic                  r_full;
   logic                  r_empty;

   logic                  w_push;
   logic                  w_pop;
   logic                  w_clear;
   logic                  w_stored_nz;
   logic                  w_wr_en;
   logic                  w_rd_en;
   logic [ADDR_WIDTH:0]   w_count_nxt;
   logic [DATA_WIDTH-1:0] w_rd_data;

   assign w_clear = rst || flush;
   assign w_push  = push_valid && push_ready;
   assign w_pop   = r_pop_valid && pop_ready;

   // Entries still in the BRAM, i.e. not yet loaded into the output stage
   assign w_stored_nz = (r_count > {{ADDR_WIDTH{1'b0}}, r_pop_valid});

   // A push during flush is dropped; nothing is fetched on a clearing edge
   assign w_wr_en = w_push && !flush;

   // Fetch when the output stage is empty or being vacated and something is
   // available; with nothing stored the read address equals the write address
   // and the RAM bypass returns the word being pushed.
   assign w_rd_en = !w_clear && (!r_pop_valid || w_pop) && (w_stored_nz || w_push);

   // Occupancy after this edge
   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
      else if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
   end

   // Pointers, occupancy and status flags
   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_pop_valid <= 1'b0;
         r_full      <= 1'b0;
         r_empty     <= 1'b1;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
         r_count     <= w_count_nxt;
         r_pop_valid <= (w_count_nxt != '0);
         r_full      <= (w_count_nxt == C_DEPTH);
         r_empty     <= (w_count_nxt == '0);
      end
   end

   bram_1r1w #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .DATA_WIDTH  (DATA_WIDTH),
      .READ_BYPASS (1'b1)
   ) u_bram (
      .clk       (clk),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (push_data),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_rd_data)
   );

   assign push_ready = !rst && !r_full;
   assign pop_valid  = r_pop_valid;
   assign pop_data   = w_rd_data;
   assign count      = r_count;
   assign full       = r_full;
   assign empty      = r_empty;
endmodule

// File: doc/bram_fifo_ctrl.md
Name: bram_fifo_ctrl

Overview:
- Synchronous valid/ready FIFO controller built around one internal bram_1r1w instance.
- The instance is configured with READ_BYPASS=1.
- Owns the read and write pointers and the occupancy count.
- Sequences BRAM reads so that pop_data is a registered, first-word-fall-through output despite the 1-cycle BRAM read latency.
- Used for decoupling pipeline stages: fetch queue, store buffer, debug trace.

Parameters:
- ADDR_WIDTH, 4, BRAM address width. Total FIFO capacity DEPTH = 2**ADDR_WIDTH entries, output stage included.
- DATA_WIDTH, 32, width of each entry.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of all contents; same effect as rst, except push_ready is not forced low.
- push_valid  input  1  producer offers push_data.
- push_ready  output  1  FIFO accepts this cycle.
- push_data  input  DATA_WIDTH  entry to enqueue.
- pop_valid  output  1  pop_data holds the oldest entry.
- pop_ready  input  1  consumer takes pop_data this cycle.
- pop_data  output  DATA_WIDTH  oldest entry.
- count  output  ADDR_WIDTH+1  number of entries held, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Handshakes:
  - Push occurs on an edge where push_valid && push_ready.
  - Pop occurs on an edge where pop_valid && pop_ready.
- Reset (rst high at an edge), values in the following cycle:
  - count=0, empty=1, full=0, pop_valid=0.
  - Pointers are 0.
  - pop_data is don't-care while pop_valid=0.
- push_ready is 0 in any cycle where rst is high; otherwise push_ready = !full.
- push_ready does not depend on pop_ready: no pass-through when full.
- pop_valid = (count != 0). It is registered and depends only on state, never combinationally on push_valid or pop_ready.
- Latency:
  - Push accepted at edge N into an empty FIFO gives pop_valid=1 and pop_data = that entry in cycle N+1.
  - After a pop, if count remains nonzero, the next entry is on pop_data in the very next cycle. There are no bubbles at any occupancy.
- Stability: while pop_valid && !pop_ready, pop_data and pop_valid hold.
- Ordering: strict FIFO order; no entry is lost or duplicated.
- Count update per edge: push only → +1; pop only → -1; both → unchanged.
- Simultaneous push and pop:
  - Permitted at any count in 1..DEPTH-1.
  - At count=DEPTH, push_ready=0, so pop only.
  - At count=0, pop_valid=0, so push only.
- BRAM sequencing:
  - Write pointer and read pointer wrap modulo DEPTH, with no special case at the wrap.
  - The BRAM read is issued early enough to meet the latency above.
  - A read of the address being written in the same cycle relies on the instance's bypass to return the new data.
  - rd_en is asserted only when a new entry must be fetched into the output stage.
- Reset or flush mid-stream:
  - All entries are discarded; any in-flight BRAM read result is ignored.
  - A push in the same cycle as flush is dropped. Because push_ready stays 1 on flush, the producer sees the push accepted and must treat flush as a discard.
  - A pop in the same cycle as flush completes normally from the consumer's view.
- Illegal use: push_data changing while push_valid && !push_ready is allowed and not checked.

Test Plan:
- Reset, then push 0xA1 at edge 1 with pop_ready=0 → cycle 2: pop_valid=1, pop_data=0xA1, count=1, empty=0; pop_data holds 0xA1 for 5 cycles.
- With ADDR_WIDTH=4, push 0x00..0x0F back-to-back with pop_ready=0 → count=16, full=1, push_ready=0; a 17th push_valid is not accepted; then pop with pop_ready=1 for 16 cycles → 0x00..0x0F in order, no gaps, then empty=1.
- Continuous push of an incrementing pattern for 100 cycles with pop_ready=1 from cycle 1 → pop_data increments every cycle after the first, count stays at 1 or 0, pointers wrap more than 6 times with no corruption.
- At count=DEPTH, push_valid=1 and pop_ready=1 → pop occurs, no push, count=DEPTH-1; next cycle push_ready=1.
- At count=3, assert flush together with push_valid=1 → next cycle: count=0, pop_valid=0, and the pushed data never appears at the output.
- Randomized push_valid and pop_ready (50% each, 10k cycles) against a reference queue model → all pops match, count matches, and pop_data is stable under backpressure.
